// File: rtl/event_part_tracker.sv
// rtl/event_part_tracker.sv - windowed x/y event counter with a ready/valid report slot
module event_part_tracker #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x_part,
  input  logic             y_part,
  input  logic             rpt_ready,
  input  logic             clr_ovf,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_x_cnt,
  output logic [CNT_W-1:0] rpt_y_cnt,
  output logic [CNT_W-1:0] rpt_both_cnt,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);

  state_t           state, state_nx;
  logic             x_q, y_q;
  logic [CNT_W-1:0] x_cnt, y_cnt, both_cnt;
  logic [15:0]      win_cnt;

  logic             x_rise, y_rise, both_hi;
  logic             counting, win_end, slot_free, load, drop;
  logic [CNT_W-1:0] x_tot, y_tot, both_tot;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en)  state_nx = RUN;
      RUN:     if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    x_rise    = x_part & ~x_q;
    y_rise    = y_part & ~y_q;
    both_hi   = x_part & y_part;
    counting  = (state == RUN) && en;
    win_end   = counting && (win_cnt == WIN_LAST);
    // A same-cycle accept frees the slot for the incoming totals.
    slot_free = !rpt_valid || rpt_ready;
    load      = win_end && slot_free;
    drop      = win_end && !slot_free;
    x_tot     = (x_cnt == CNT_MAX)    ? CNT_MAX : x_cnt    + CNT_W'(x_rise);
    y_tot     = (y_cnt == CNT_MAX)    ? CNT_MAX : y_cnt    + CNT_W'(y_rise);
    both_tot  = (both_cnt == CNT_MAX) ? CNT_MAX : both_cnt + CNT_W'(both_hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x_q          <= 1'b0;
      y_q          <= 1'b0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      both_cnt     <= '0;
      win_cnt      <= '0;
      rpt_valid    <= 1'b0;
      rpt_x_cnt    <= '0;
      rpt_y_cnt    <= '0;
      rpt_both_cnt <= '0;
      ovf          <= 1'b0;
    end else begin
      state <= state_nx;
      x_q   <= x_part;
      y_q   <= y_part;

      // Any non-counting cycle (idle, or the disable cycle) discards the partial window.
      if (counting && !win_end) begin
        x_cnt    <= x_tot;
        y_cnt    <= y_tot;
        both_cnt <= both_tot;
        win_cnt  <= win_cnt + 16'd1;
      end else begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        both_cnt <= '0;
        win_cnt  <= '0;
      end

      if (load) begin
        rpt_valid    <= 1'b1;
        rpt_x_cnt    <= x_tot;
        rpt_y_cnt    <= y_tot;
        rpt_both_cnt <= both_tot;
      end else if (rpt_valid && rpt_ready) begin
        rpt_valid <= 1'b0;
      end

      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  assign busy = (state == RUN);

endmodule
